// File: rtl/cipher_bridge_pkg.sv
// Shared widths, FSM state encoding and word-slicing helpers for the cipher word bridge.
// Blocks use big-endian bit numbering [0:BLOCK_W-1], so word 0 is the most significant.
package cipher_bridge_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 64;
    localparam int WORD_W  = 32;
    localparam int TO_W    = 24;
    localparam int N_WORDS = BLOCK_W / WORD_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bridge_state_e;

    typedef logic [1:0] word_idx_t;

    // Word k occupies bits [WORD_W*k : WORD_W*k+WORD_W-1] of a block.
    function automatic logic [WORD_W-1:0] block_word(input logic [0:BLOCK_W-1] blk,
                                                     input word_idx_t           k);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (k == word_idx_t'(i)) begin
                w = blk[i*WORD_W +: WORD_W];
            end
        end
        return w;
    endfunction

    function automatic logic [0:BLOCK_W-1] block_put(input logic [0:BLOCK_W-1] blk,
                                                     input word_idx_t           k,
                                                     input logic [WORD_W-1:0]   w);
        logic [0:BLOCK_W-1] b;
        b = blk;
        for (int i = 0; i < N_WORDS; i++) begin
            if (k == word_idx_t'(i)) begin
                b[i*WORD_W +: WORD_W] = w;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/cipher_word_bridge.sv
// Bridges a 32-bit word stream to a 128-bit block cipher handshake and back:
// assembles four words into Plain, runs the cipher, then streams the result out.
module cipher_word_bridge
    import cipher_bridge_pkg::*;
#(
    parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF,
    parameter int              WORDS   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               key_load,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic [0:BLOCK_W-1] Plain,
    output logic [0:KEY_W-1]   Key,
    output logic               encrypt_start,
    input  logic               encrypt_end,
    input  logic [0:BLOCK_W-1] Cipher,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic               error
);

    localparam word_idx_t LAST_IDX = word_idx_t'(WORDS - 1);

    bridge_state_e      state_q, state_d;
    word_idx_t          idx_q, idx_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [0:BLOCK_W-1] plain_q, plain_d;
    logic [0:KEY_W-1]   key_q, key_d;
    logic [0:BLOCK_W-1] cap_q, cap_d;
    logic               start_q, start_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               error_q, error_d;

    logic               in_fire;
    logic               out_fire;
    logic [TO_W-1:0]    cnt_inc;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a variable unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        plain_d     = plain_q;
        key_d       = key_q;
        cap_d       = cap_q;
        start_d     = start_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        error_d     = error_q;

        case (state_q)
            FILL: begin
                in_ready_d = 1'b1;
                if (key_load && idx_q == '0) begin
                    key_d = key_in;
                end
                if (in_fire) begin
                    plain_d = block_put(plain_q, idx_q, in_data);
                    if (idx_q == LAST_IDX) begin
                        state_d    = RUN;
                        in_ready_d = 1'b0;
                        start_d    = 1'b1;
                        idx_d      = '0;
                        cnt_d      = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            RUN: begin
                in_ready_d = 1'b0;
                if (encrypt_end) begin
                    // A completion arriving on the timeout cycle still wins.
                    cap_d       = Cipher;
                    start_d     = 1'b0;
                    state_d     = DRAIN;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = block_word(Cipher, '0);
                    out_last_d  = 1'b0;
                end else if (cnt_inc == TIMEOUT) begin
                    error_d    = 1'b1;
                    start_d    = 1'b0;
                    state_d    = FILL;
                    in_ready_d = 1'b1;
                    idx_d      = '0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            DRAIN: begin
                in_ready_d = 1'b0;
                if (out_fire) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = FILL;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = '0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_data_d = block_word(cap_q, idx_q + 1'b1);
                        out_last_d = (idx_q + 1'b1) == LAST_IDX;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FILL;
            idx_q       <= '0;
            cnt_q       <= '0;
            plain_q     <= '0;
            key_q       <= '0;
            cap_q       <= '0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            plain_q     <= plain_d;
            key_q       <= key_d;
            cap_q       <= cap_d;
            start_q     <= start_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            error_q     <= error_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign Plain         = plain_q;
    assign Key           = key_q;
    assign encrypt_start = start_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_last      = out_last_q;
    assign error         = error_q;

endmodule

// File: tb/tb_cipher_word_bridge.sv
// Randomized self-checking bench for cipher_word_bridge with a block-level reference model
// and an in-bench cipher stub whose latency is chosen per block.
module tb_cipher_word_bridge;

    localparam logic [23:0] TO = 24'd16;

    logic         clock;
    logic         reset;
    logic [63:0]  key_in;
    logic         key_load;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] plain_o;
    logic [63:0]  key_o;
    logic         encrypt_start;
    logic         encrypt_end;
    logic [127:0] cipher_i;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         error;

    cipher_word_bridge #(.TIMEOUT(TO), .WORDS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .key_in        (key_in),
        .key_load      (key_load),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .Plain         (plain_o),
        .Key           (key_o),
        .encrypt_start (encrypt_start),
        .encrypt_end   (encrypt_end),
        .Cipher        (cipher_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .error         (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_errors = 0;

    // Reference model state
    logic [31:0]  blk [4];
    logic [63:0]  exp_key;
    logic [127:0] exp_cipher;
    bit           exp_error;
    bit           filling;
    int           words_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] cipher_fn(input logic [127:0] p, input logic [63:0] k);
        logic [127:0] x;
        x = p ^ {k, ~k};
        return {x[118:0], x[127:119]} + 128'd1;
    endfunction

    function automatic logic [127:0] plain_of();
        return {blk[0], blk[1], blk[2], blk[3]};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] c, input int k);
        return c[127-32*k -: 32];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_plain"},  plain_o, 0);
        check({tag, "_key"},    key_o, 0);
        check({tag, "_start"},  encrypt_start, 0);
        check({tag, "_ready"},  in_ready, 0);
        check({tag, "_ovalid"}, out_valid, 0);
        check({tag, "_odata"},  out_data, 0);
        check({tag, "_olast"},  out_last, 0);
        check({tag, "_error"},  error, 0);
    endtask

    task automatic do_reset(input string tag);
        in_valid    = 1'b0;
        key_load    = 1'b0;
        encrypt_end = 1'b0;
        out_ready   = 1'b0;
        reset       = 1'b1;
        step();
        check_all_zero(tag);
        reset     = 1'b0;
        exp_key   = '0;
        exp_error = 1'b0;
        filling   = 1'b1;
        words_in  = 0;
        step();
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_start_after"}, encrypt_start, 0);
    endtask

    task automatic key_pulse(input string tag, input logic [63:0] kv);
        key_load = 1'b1;
        key_in   = kv;
        if (filling && words_in == 0) exp_key = kv;
        step();
        key_load = 1'b0;
        check(tag, key_o, exp_key);
    endtask

    task automatic send_word(input logic [31:0] w, input bit with_key, input logic [63:0] kv);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = w;
        key_load = with_key;
        key_in   = kv;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        if (with_key && filling && words_in == 0) exp_key = kv;
        step();
        in_valid = 1'b0;
        key_load = 1'b0;
        words_in++;
    endtask

    task automatic feed_range(input int from, input int to, input bit key_w0, input logic [63:0] kv);
        for (int k = from; k <= to; k++) begin
            repeat ($urandom_range(0, 2)) step();
            send_word(blk[k], key_w0 && k == 0, kv);
            if (k < 3) check("fill_start_low", encrypt_start, 0);
        end
        if (to == 3) begin
            filling  = 1'b0;
            words_in = 0;
            check("start_rise", encrypt_start, 1);
            check("run_not_ready", in_ready, 0);
            check("plain", plain_o, plain_of());
            check("key_at_run", key_o, exp_key);
        end
    endtask

    // Cipher stub: waits lat cycles, then returns the model cipher with a one-cycle encrypt_end.
    task automatic respond(input int lat);
        for (int i = 0; i < lat; i++) begin
            encrypt_end = 1'b0;
            cipher_i    = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) begin
                key_load = 1'b1;
                key_in   = {$urandom, $urandom};
            end
            step();
            key_load = 1'b0;
        end
        check("start_held", encrypt_start, 1);
        check("plain_held", plain_o, plain_of());
        check("key_held", key_o, exp_key);
        exp_cipher  = cipher_fn(plain_of(), exp_key);
        cipher_i    = exp_cipher;
        encrypt_end = 1'b1;
        step();
        encrypt_end = 1'b0;
        cipher_i    = {$urandom, $urandom, $urandom, $urandom};
        check("start_drop", encrypt_start, 0);
        check("drain_valid", out_valid, 1);
    endtask

    task automatic drain(input int max_stall, input int force_k);
        int stall;
        for (int k = 0; k < 4; k++) begin
            stall     = (k == force_k) ? 5 : int'($urandom_range(0, max_stall));
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                step();
                check("stall_data", out_data, word_of(exp_cipher, k));
                check("stall_last", out_last, k == 3);
                check("stall_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            check("out_valid", out_valid, 1);
            check("out_data", out_data, word_of(exp_cipher, k));
            check("out_last", out_last, k == 3);
            step();
        end
        out_ready = 1'b0;
        filling   = 1'b1;
        words_in  = 0;
        check("drain_done_valid", out_valid, 0);
        check("drain_done_ready", in_ready, 1);
        check("error_sticky", error, exp_error);
    endtask

    task automatic rand_block();
        for (int k = 0; k < 4; k++) blk[k] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        key_in      = '0;
        key_load    = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        encrypt_end = 1'b0;
        cipher_i    = '0;
        out_ready   = 1'b0;
        exp_key     = '0;
        exp_error   = 1'b0;
        exp_cipher  = '0;
        filling     = 1'b1;
        words_in    = 0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check("ready_after_reset", in_ready, 1);

        // encrypt_end outside RUN has no effect
        cipher_i    = {$urandom, $urandom, $urandom, $urandom};
        encrypt_end = 1'b1;
        step();
        encrypt_end = 1'b0;
        check("stray_end_valid", out_valid, 0);
        check("stray_end_start", encrypt_start, 0);

        // basic
        key_pulse("basic_key", 64'h0);
        blk = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        feed_range(0, 3, 1'b0, '0);
        check("basic_plain_const", plain_o, {128{1'b1}});
        respond(2);
        drain(0, -1);

        // word order
        blk = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        feed_range(0, 3, 1'b0, '0);
        check("order_plain_const", plain_o, 128'h000102030405060708090A0B0C0D0E0F);
        respond(1);
        drain(0, -1);

        // back-pressure
        rand_block();
        feed_range(0, 3, 1'b0, '0);
        respond(3);
        drain(1, 1);

        // key gating: ignored mid-block, honoured at index 0, and together with word 0
        rand_block();
        feed_range(0, 1, 1'b0, '0);
        key_pulse("key_gated", 64'h0123456789ABCDEF);
        feed_range(2, 3, 1'b0, '0);
        respond(2);
        drain(0, -1);
        key_pulse("key_idx0", 64'h0123456789ABCDEF);
        check("key_idx0_const", key_o, 64'h0123456789ABCDEF);
        rand_block();
        feed_range(0, 3, 1'b1, 64'hFEDCBA9876543210);
        check("key_with_word0", key_o, 64'hFEDCBA9876543210);
        respond(0);
        drain(2, -1);

        // timeout, then a normal block
        rand_block();
        feed_range(0, 3, 1'b0, '0);
        repeat (int'(TO) - 1) step();
        check("pre_timeout_error", error, 0);
        check("pre_timeout_start", encrypt_start, 1);
        step();
        exp_error = 1'b1;
        filling   = 1'b1;
        check("timeout_error", error, 1);
        check("timeout_start", encrypt_start, 0);
        check("timeout_ready", in_ready, 1);
        check("timeout_valid", out_valid, 0);
        rand_block();
        feed_range(0, 3, 1'b0, '0);
        respond(4);
        drain(2, -1);

        // completion on the last allowed cycle beats the timeout
        rand_block();
        feed_range(0, 3, 1'b0, '0);
        respond(int'(TO) - 1);
        check("late_end_error", error, 1);
        drain(0, -1);

        // reset mid-RUN
        rand_block();
        feed_range(0, 3, 1'b0, '0);
        step();
        step();
        do_reset("rst_run");

        // reset mid-DRAIN
        rand_block();
        feed_range(0, 3, 1'b0, '0);
        respond(1);
        step();
        do_reset("rst_drain");

        // randomized blocks
        for (int b = 0; b < 12; b++) begin
            rand_block();
            if ($urandom_range(0, 1) == 1) key_pulse("rand_key", {$urandom, $urandom});
            feed_range(0, 3, $urandom_range(0, 1) == 1, {$urandom, $urandom});
            respond(int'($urandom_range(0, 10)));
            drain(3, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
